// File: rtl/parking_timer_if.sv
// Bundle between the parking FSM / multiplexed display and parking_timer.
// master drives the event pulses and reads the display fields.
// slave is the timer side.
interface parking_timer_if;
  logic       tick_1hz;
  logic       entry_pulse;
  logic [1:0] entry_slot;
  logic       exit_pulse;
  logic [1:0] exit_slot;
  logic       mode;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [3:0] active;

  modport master (
    output tick_1hz, entry_pulse, entry_slot, exit_pulse, exit_slot,
    input  mode, minutes, seconds, active
  );

  modport slave (
    input  tick_1hz, entry_pulse, entry_slot, exit_pulse, exit_slot,
    output mode, minutes, seconds, active
  );
endinterface

// File: rtl/parking_timer.sv
// parking_timer: four per-slot mm:ss timers plus a display FSM.
// After a car leaves, the FSM shows that slot's elapsed time for SHOW_TICKS
// seconds, then returns the display to capacity mode.
// Build option: define PARKING_TIMER_SAT_EN to make a slot saturate at 59:59.
// Leave it undefined and a slot wraps to 00:00 and keeps counting.

// One slot timer.
// start (entry) has priority over stop (exit), so an exit and an entry on
// the same slot in one cycle restart the slot. The exit still sees the old
// time, because the top latches it from the pre-edge registers.
// stop also beats tick, so an exiting slot never increments.
module parking_slot (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  output logic       act,
  output logic [5:0] mm,
  output logic [5:0] ss
);

  // run flag and mm:ss counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act <= 1'b0;
      mm  <= '0;
      ss  <= '0;
    end else if (start) begin
      act <= 1'b1;
      mm  <= '0;
      ss  <= '0;
    end else if (stop) begin
      act <= 1'b0;
    end else if (tick && act) begin
      if (ss != 6'd59) begin
        ss <= ss + 6'd1;
      end else if (mm != 6'd59) begin
        ss <= '0;
        mm <= mm + 6'd1;
      end else begin
`ifdef PARKING_TIMER_SAT_EN
        ss <= ss;
        mm <= mm;
`else
        ss <= '0;
        mm <= '0;
`endif
      end
    end
  end

endmodule

module parking_timer #(
  parameter int unsigned SHOW_TICKS = 5
) (
  input  logic            clk,
  input  logic            reset,
  parking_timer_if.slave  bus
);

  localparam int unsigned NUM_SLOTS = 4;
  localparam logic [0:0]  S_IDLE    = 1'b0;
  localparam logic [0:0]  S_SHOW    = 1'b1;
  localparam logic [3:0]  SHOW_LD   = SHOW_TICKS[3:0];

  logic [NUM_SLOTS-1:0]       act_vec;
  logic [NUM_SLOTS-1:0][5:0]  mm_arr;
  logic [NUM_SLOTS-1:0][5:0]  ss_arr;
  logic [NUM_SLOTS-1:0]       start_vec;
  logic [NUM_SLOTS-1:0]       stop_vec;
  logic                       valid_exit;

  logic [0:0] state;
  logic [3:0] cnt;
  logic [5:0] min_r;
  logic [5:0] sec_r;

  // An exit counts only if the slot is running.
  // An exit of an empty slot is dropped.
  assign valid_exit = bus.exit_pulse && act_vec[bus.exit_slot];
  assign start_vec  = bus.entry_pulse ? (NUM_SLOTS'(1) << bus.entry_slot) : '0;
  assign stop_vec   = valid_exit      ? (NUM_SLOTS'(1) << bus.exit_slot)  : '0;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    parking_slot u_slot (
      .clk   (clk),
      .reset (reset),
      .tick  (bus.tick_1hz),
      .start (start_vec[g]),
      .stop  (stop_vec[g]),
      .act   (act_vec[g]),
      .mm    (mm_arr[g]),
      .ss    (ss_arr[g])
    );
  end

  // Display FSM.
  // Shown time and countdown are registered.
  // A tick on the exit edge is absorbed by the reload, so it is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      min_r <= '0;
      sec_r <= '0;
    end else if (valid_exit) begin
      state <= S_SHOW;
      cnt   <= SHOW_LD;
      min_r <= mm_arr[bus.exit_slot];
      sec_r <= ss_arr[bus.exit_slot];
    end else if (state == S_SHOW && bus.tick_1hz) begin
      if (cnt == 4'd1) begin
        state <= S_IDLE;
        cnt   <= '0;
        min_r <= '0;
        sec_r <= '0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign bus.mode    = state[0];
  assign bus.minutes = min_r;
  assign bus.seconds = sec_r;
  assign bus.active  = act_vec;

endmodule

// File: tb/tb_parking_timer.sv
// Self-checking bench for parking_timer.
// Each slot is modelled as a running flag plus elapsed seconds.
// The display is modelled as shown value plus seconds left.
module tb_parking_timer;

  localparam int SHOW_T = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  parking_timer_if bus ();

  parking_timer #(.SHOW_TICKS(SHOW_T)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model
  bit m_act [4];
  int m_el  [4];
  bit d_mode;
  int d_time;
  int d_left;

  function automatic logic [16:0] exp_vec();
    logic [3:0] a;
    for (int i = 0; i < 4; i++) a[i] = m_act[i];
    return {d_mode, 6'(d_time / 60), 6'(d_time % 60), a};
  endfunction

  function automatic logic [16:0] got_vec();
    return {bus.mode, bus.minutes, bus.seconds, bus.active};
  endfunction

  function automatic int inc_time(input int e);
`ifdef PARKING_TIMER_SAT_EN
    return (e < 3599) ? e + 1 : 3599;
`else
    return (e + 1) % 3600;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 0;
      m_el[i] = 0;
    end
    d_mode = 0;
    d_time = 0;
    d_left = 0;
  endtask

  task automatic model_step(input bit t, input bit en, input int es, input bit ex, input int xs);
    bit valid;
    valid = ex && m_act[xs];
    if (valid) begin
      d_mode = 1;
      d_time = m_el[xs];
      d_left = SHOW_T;
    end else if (d_mode && t) begin
      d_left--;
      if (d_left == 0) begin
        d_mode = 0;
        d_time = 0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (en && es == i) begin
        m_act[i] = 1;
        m_el[i] = 0;
      end else if (valid && xs == i) begin
        m_act[i] = 0;
      end else if (t && m_act[i]) begin
        m_el[i] = inc_time(m_el[i]);
      end
    end
  endtask

  // One clock of stimulus.
  // Inputs are driven at negedge and the model advances at posedge.
  // Outputs settle by #1 after the edge.
  task automatic cycle(input bit t, input bit en, input bit [1:0] es, input bit ex, input bit [1:0] xs);
    @(negedge clk);
    bus.tick_1hz    = t;
    bus.entry_pulse = en;
    bus.entry_slot  = es;
    bus.exit_pulse  = ex;
    bus.exit_slot   = xs;
    @(posedge clk);
    model_step(t, en, int'(es), ex, int'(xs));
    #1;
    bus.tick_1hz    = 0;
    bus.entry_pulse = 0;
    bus.exit_pulse  = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1;
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (got_vec() !== 17'd0) begin
      errors++;
      $display("FAIL reset_state got=%h want=0", got_vec());
    end
    cycle(0, 1, 1, 0, 0);
    ticks(7);
    checks++;
    if (got_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL pre_reset_count got=%h want=%h", got_vec(), exp_vec());
    end
    // assert reset between edges; clear must be immediate
    @(negedge clk);
    #2 reset = 1;
    model_reset();
    #1;
    checks++;
    if (got_vec() !== 17'd0) begin
      errors++;
      $display("FAIL async_reset got=%h want=0", got_vec());
    end
    @(negedge clk);
    reset = 0;
    ticks(3);
    checks++;
    if (bus.active !== 4'b0000) begin
      errors++;
      $display("FAIL no_count_after_reset active=%b want=0000", bus.active);
    end
    cycle(0, 1, 1, 0, 0);
    ticks(2);
    cycle(0, 0, 0, 1, 1);
    checks++;
    if (got_vec() !== {1'b1, 6'd0, 6'd2, 4'b0000}) begin
      errors++;
      $display("FAIL restart_after_reset got=%h want=%h", got_vec(), {1'b1, 6'd0, 6'd2, 4'b0000});
    end
  endtask

  task automatic test_basic();
    apply_reset();
    cycle(0, 1, 2, 0, 0);
    checks++;
    if (bus.active !== 4'b0100) begin
      errors++;
      $display("FAIL entry_active got=%b want=0100", bus.active);
    end
    for (int i = 0; i < 75; i++) begin
      cycle(1, 0, 0, 0, 0);
      if ($urandom_range(3) == 0) cycle(0, 0, 0, 0, 0);
    end
    cycle(0, 0, 0, 1, 2);
    checks++;
    if (got_vec() !== {1'b1, 6'd1, 6'd15, 4'b0000}) begin
      errors++;
      $display("FAIL exit_75 got=%h want=%h", got_vec(), {1'b1, 6'd1, 6'd15, 4'b0000});
    end
    for (int i = 1; i <= SHOW_T; i++) begin
      cycle(1, 0, 0, 0, 0);
      checks++;
      if (bus.mode !== (i < SHOW_T) || got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL countdown_%0d got=%h want=%h", i, got_vec(), exp_vec());
      end
    end
    checks++;
    if (got_vec() !== 17'd0) begin
      errors++;
      $display("FAIL back_to_idle got=%h want=0", got_vec());
    end
  endtask

  task automatic test_inactive_exit();
    apply_reset();
    cycle(0, 1, 0, 0, 0);
    ticks(3);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 3);
    checks++;
    if (got_vec() !== {1'b1, 6'd0, 6'd3, 4'b0000}) begin
      errors++;
      $display("FAIL inactive_exit got=%h want=%h", got_vec(), {1'b1, 6'd0, 6'd3, 4'b0000});
    end
    apply_reset();
    cycle(0, 0, 0, 1, 3);
    checks++;
    if (got_vec() !== 17'd0) begin
      errors++;
      $display("FAIL inactive_exit_idle got=%h want=0", got_vec());
    end
  endtask

  task automatic test_exit_tick();
    apply_reset();
    cycle(0, 1, 0, 0, 0);
    ticks(6);
    cycle(0, 1, 1, 0, 0);
    ticks(3);
    cycle(1, 0, 0, 1, 0);
    checks++;
    if (got_vec() !== {1'b1, 6'd0, 6'd9, 4'b0010}) begin
      errors++;
      $display("FAIL exit_with_tick got=%h want=%h", got_vec(), {1'b1, 6'd0, 6'd9, 4'b0010});
    end
    cycle(0, 0, 0, 1, 1);
    checks++;
    if (got_vec() !== {1'b1, 6'd0, 6'd4, 4'b0000}) begin
      errors++;
      $display("FAIL other_slot_ticked got=%h want=%h", got_vec(), {1'b1, 6'd0, 6'd4, 4'b0000});
    end
    // entry coincident with tick leaves the slot at 00:00
    cycle(1, 1, 3, 0, 0);
    cycle(0, 0, 0, 1, 3);
    checks++;
    if (got_vec() !== {1'b1, 6'd0, 6'd0, 4'b0000}) begin
      errors++;
      $display("FAIL entry_with_tick got=%h want=%h", got_vec(), {1'b1, 6'd0, 6'd0, 4'b0000});
    end
  endtask

  task automatic test_rollover();
    logic [16:0] want;
`ifdef PARKING_TIMER_SAT_EN
    want = {1'b1, 6'd59, 6'd59, 4'b0000};
`else
    want = {1'b1, 6'd0, 6'd0, 4'b0000};
`endif
    apply_reset();
    cycle(0, 1, 0, 0, 0);
    ticks(3600);
    cycle(0, 0, 0, 1, 0);
    checks++;
    if (got_vec() !== want || got_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL rollover got=%h want=%h", got_vec(), want);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    cycle(0, 1, 1, 0, 0);
    ticks(14);
    cycle(0, 1, 0, 0, 0);
    ticks(4);
    cycle(0, 0, 0, 1, 0);
    checks++;
    if (got_vec() !== {1'b1, 6'd0, 6'd4, 4'b0010}) begin
      errors++;
      $display("FAIL first_exit got=%h want=%h", got_vec(), {1'b1, 6'd0, 6'd4, 4'b0010});
    end
    ticks(2);
    cycle(0, 0, 0, 1, 1);
    checks++;
    if (got_vec() !== {1'b1, 6'd0, 6'd20, 4'b0000}) begin
      errors++;
      $display("FAIL second_exit got=%h want=%h", got_vec(), {1'b1, 6'd0, 6'd20, 4'b0000});
    end
    for (int i = 1; i <= SHOW_T; i++) begin
      cycle(1, 0, 0, 0, 0);
      checks++;
      if (bus.mode !== (i < SHOW_T)) begin
        errors++;
        $display("FAIL reload_hold_%0d mode=%b want=%b", i, bus.mode, (i < SHOW_T));
      end
    end
  endtask

  task automatic test_same_slot();
    apply_reset();
    cycle(0, 1, 2, 0, 0);
    ticks(10);
    cycle(1, 1, 2, 1, 2);
    checks++;
    if (got_vec() !== {1'b1, 6'd0, 6'd10, 4'b0100}) begin
      errors++;
      $display("FAIL same_slot got=%h want=%h", got_vec(), {1'b1, 6'd0, 6'd10, 4'b0100});
    end
    ticks(3);
    cycle(0, 0, 0, 1, 2);
    checks++;
    if (got_vec() !== {1'b1, 6'd0, 6'd3, 4'b0000}) begin
      errors++;
      $display("FAIL same_slot_restart got=%h want=%h", got_vec(), {1'b1, 6'd0, 6'd3, 4'b0000});
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(2) == 0, $urandom_range(7) == 0, 2'($urandom_range(3)),
            $urandom_range(5) == 0, 2'($urandom_range(3)));
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        if (bad < 10) $display("FAIL random_%0d got=%h want=%h", i, got_vec(), exp_vec());
        bad++;
      end
    end
  endtask

  initial begin
    bus.tick_1hz    = 0;
    bus.entry_pulse = 0;
    bus.entry_slot  = 0;
    bus.exit_pulse  = 0;
    bus.exit_slot   = 0;
    model_reset();
    test_reset();
    test_basic();
    test_inactive_exit();
    test_exit_tick();
    test_rollover();
    test_back_to_back();
    test_same_slot();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
